regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU result path, requester 1 is the load-data path.
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the winning write so the register file sees a clean write port one cycle after acceptance.
- Discards writes to x0 and counts arbitration conflicts for debug.

---
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and load writeback paths.
// The winning write is registered so the register file sees it one cycle after acceptance.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              lastGrant_q, lastGrant_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic [CNT_W-1:0]  conflictCnt_q, conflictCnt_d;

    logic grant0, grant1;
    logic bothValid;

    assign bothValid = req0_valid && req1_valid;

    // On a conflict the requester that did not win last time gets the port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !stall) begin
            if (bothValid) begin
                grant0 = lastGrant_q;
                grant1 = !lastGrant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        lastGrant_d   = lastGrant_q;
        wrEn_d        = 1'b0;
        wrAddr_d      = wrAddr_q;
        wrData_d      = wrData_q;
        conflictCnt_d = conflictCnt_q;
        if (grant0) begin
            lastGrant_d = 1'b0;
            wrEn_d      = (req0_addr != '0);
            wrAddr_d    = req0_addr;
            wrData_d    = req0_data;
        end else if (grant1) begin
            lastGrant_d = 1'b1;
            wrEn_d      = (req1_addr != '0);
            wrAddr_d    = req1_addr;
            wrData_d    = req1_data;
        end
        if (bothValid && !stall && conflictCnt_q != CNT_MAX) begin
            conflictCnt_d = conflictCnt_q + CNT_W'(1);
        end
    end

    // Reset starts last grant at 1 so the ALU path wins the first conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q   <= 1'b1;
            wrEn_q        <= 1'b0;
            wrAddr_q      <= '0;
            wrData_q      <= '0;
            conflictCnt_q <= '0;
        end else begin
            lastGrant_q   <= lastGrant_d;
            wrEn_q        <= wrEn_d;
            wrAddr_q      <= wrAddr_d;
            wrData_q      <= wrData_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign wr_en        = wrEn_q;
    assign wr_addr      = wrAddr_q;
    assign wr_data      = wrData_q;
    assign conflict_cnt = conflictCnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference model predicts each cycle's grants and
// queues the write port state expected one cycle later.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, stall;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] conflict_cnt;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbQueue[$];

    int checksTotal  = 0;
    int checksPassed = 0;
    int lastWinner   = -1;

    logic          mLast = 1'b1;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mData = '0;
    logic [CW-1:0] mCnt  = '0;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .req0_valid(req0_valid),
        .req0_addr(req0_addr),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr(req1_addr),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checksTotal++;
        if (obs === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, checks the same-cycle grants against the model,
    // queues the expected registered outputs and compares them after the edge.
    task automatic applyStimulus(input logic r, input logic s,
                                 input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic g0, g1;
        exp_t e, got;
        reset      = r;
        stall      = s;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r && !s) begin
            if (v0 && v1) begin
                g0 = mLast;
                g1 = !mLast;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        checkOutput("req0_ready", 64'(req0_ready), 64'(g0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(g1));
        e.en = 1'b0;
        if (r) begin
            mLast = 1'b1;
            mAddr = '0;
            mData = '0;
            mCnt  = '0;
        end else begin
            if (g0) begin
                mLast = 1'b0;
                mAddr = a0;
                mData = d0;
                e.en  = (a0 != 0);
            end else if (g1) begin
                mLast = 1'b1;
                mAddr = a1;
                mData = d1;
                e.en  = (a1 != 0);
            end
            if (v0 && v1 && !s && mCnt != 8'hFF) mCnt = mCnt + 8'd1;
        end
        lastWinner = g0 ? 0 : (g1 ? 1 : -1);
        e.addr = mAddr;
        e.data = mData;
        e.cnt  = mCnt;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sbQueue.pop_front();
            checkOutput("wr_en", 64'(wr_en), 64'(got.en));
            checkOutput("wr_addr", 64'(wr_addr), 64'(got.addr));
            checkOutput("wr_data", 64'(wr_data), 64'(got.data));
            checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(got.cnt));
        end
    endtask

    task automatic idle(input logic r);
        applyStimulus(r, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [CW-1:0] cntBefore;
        reset      = 1'b1;
        stall      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        // Reset, including a request presented during reset that must be ignored.
        idle(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_cnt", 64'(conflict_cnt), 64'd0);

        // Single ALU write.
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA, 1'b0, '0, '0);
        checkOutput("t1_wr_en", 64'(wr_en), 64'd1);
        checkOutput("t1_wr_addr", 64'(wr_addr), 64'd5);
        checkOutput("t1_wr_data", 64'(wr_data), 64'hAA);
        idle(1'b0);
        checkOutput("t1_idle_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t1_hold_addr", 64'(wr_addr), 64'd5);

        // Back-to-back conflicts alternate grants.
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222);
            checkOutput("t2_winner", 64'(lastWinner), 64'((i % 2 == 0) ? 0 : 1));
            checkOutput("t2_wr_addr", 64'(wr_addr), 64'((i % 2 == 0) ? 1 : 2));
            checkOutput("t2_wr_en", 64'(wr_en), 64'd1);
        end
        checkOutput("t2_cnt", 64'(conflict_cnt), 64'd4);

        // Load write to x0 is accepted but suppressed; ALU then wins the next conflict.
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        checkOutput("t3_winner", 64'(lastWinner), 64'd1);
        checkOutput("t3_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t3_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0);
        checkOutput("t3_conflict_winner", 64'(lastWinner), 64'd0);

        // Stall blocks grants and counting; release grants the opposite of the last winner.
        cntBefore = conflict_cnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
            checkOutput("t4_stall_wr_en", 64'(wr_en), 64'd0);
        end
        checkOutput("t4_stall_cnt", 64'(conflict_cnt), 64'(cntBefore));
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
        checkOutput("t4_release_winner", 64'(lastWinner), 64'd1);
        checkOutput("t4_release_addr", 64'(wr_addr), 64'd12);

        // Counter saturation.
        idle(1'b1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'(i % 31 + 1), 32'(i), 1'b1, 5'((i + 7) % 31 + 1), 32'(i + 1000));
        end
        checkOutput("t5_saturated", 64'(conflict_cnt), 64'd255);

        // Reset straight after a grant.
        idle(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
        checkOutput("t6_granted", 64'(wr_en), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        checkOutput("t6_wr_en", 64'(wr_en), 64'd0);
        checkOutput("t6_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("t6_wr_data", 64'(wr_data), 64'd0);
        checkOutput("t6_cnt", 64'(conflict_cnt), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        checkOutput("t6_first_winner", 64'(lastWinner), 64'd0);

        // Same destination from both requesters, written in grant order.
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd3, 32'h301);
        checkOutput("same_dst_data", 64'(wr_data), 64'h301);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 32'h300, 1'b0, '0, '0);
        checkOutput("same_dst_data2", 64'(wr_data), 64'h300);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
